// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in and RAM write port of the program loader
interface program_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    // master: byte source and RAM side; slave: the loader itself
    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a checksummed image from a byte stream into CPU RAM
module program_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    program_loader_if.slave     bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    // Timer also runs through WRITE, so the abort lands TIMEOUT cycles after a handshake
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] data_q;
    logic [TW-1:0]         timer;
    logic                  hs;

    assign hs = (state == S_RECV) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            sum    <= '0;
            data_q <= '0;
            timer  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state <= S_RECV;
                        count <= '0;
                        sum   <= '0;
                        timer <= '0;
                    end
                end
                S_RECV: begin
                    if (hs) begin
                        data_q <= bus.in_data;
                        timer  <= '0;
                        state  <= (count == FULL) ? S_CHECK : S_WRITE;
                    end else if (timer == TIMER_LAST) begin
                        state <= S_ERROR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WRITE: begin
                    sum   <= sum + data_q;
                    count <= count + (ADDR_WIDTH+1)'(1);
                    timer <= timer + TW'(1);
                    state <= S_RECV;
                end
                S_CHECK: begin
                    state <= (data_q == sum) ? S_DONE : S_ERROR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output decodes registered state, so nothing passes straight from inputs
    assign bus.in_ready  = (state == S_RECV);
    assign bus.ram_we    = (state == S_WRITE);
    assign bus.ram_addr  = count[ADDR_WIDTH-1:0];
    assign bus.ram_wdata = data_q;

    assign cpu_hold = (state == S_RECV) || (state == S_WRITE) ||
                      (state == S_CHECK) || (state == S_ERROR);
    assign busy     = (state == S_RECV) || (state == S_WRITE) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed-vector bench for program_loader
module tb_program_loader;
    logic clk = 1'b0;
    logic rst_n, start, cpu_hold, busy, done, error;
    int   cyc, hs_cyc, total, passed;
    bit   both_seen;
    logic [7:0] img [16];
    logic [3:0] wr_a [$];
    logic [7:0] wr_d [$];

    program_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ram_we) begin
            wr_a.push_back(bus.ram_addr);
            wr_d.push_back(bus.ram_wdata);
        end
        if (done && error) both_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int n = 0;
        bit acc = 1'b0;
        bus.in_data = b;
        while (!acc && n < 100) begin
            bus.in_valid = toggle ? cyc[1] : 1'b1;
            acc = bus.in_valid && bus.in_ready;
            hs_cyc = cyc;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("byte_accept", 0, 1);
    endtask

    task automatic run_load(input logic [7:0] cks, input bit toggle, input int start_idx);
        wr_a.delete();
        wr_d.delete();
        do_start();
        for (int k = 0; k < 16; k++) begin
            if (k == start_idx) start = 1'b1;
            if (k == start_idx + 3) start = 1'b0;
            send_byte(img[k], toggle);
        end
        start = 1'b0;
        send_byte(cks, toggle);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_wr_count"}, wr_a.size(), n);
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
            check({tag, "_addr"}, wr_a[i], i);
            check({tag, "_data"}, wr_d[i], img[i]);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 10) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; passed = 0; cyc = 0; hs_cyc = 0; both_seen = 1'b0;
        rst_n = 1'b0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;

        do_reset();
        check("reset_outputs", {bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                                cpu_hold, busy, done, error}, 0);

        // nominal: 0x01..0x10, checksum 0x88, done at cycle 35
        for (int k = 0; k < 16; k++) img[k] = 8'(k + 1);
        run_load(8'h88, 1'b0, -1);
        check("nom_cks_cycle", hs_cyc, 33);
        check("nom_check_cycle", cyc, 34);
        check("nom_check_done", done, 0);
        check("nom_check_hold", cpu_hold, 1);
        step();
        check("nom_done35", done, 1);
        check("nom_hold_drop", cpu_hold, 0);
        check("nom_error", error, 0);
        check("nom_busy", busy, 0);
        check_writes("nom", 16);

        // checksum wrap with a toggling in_valid: 16 x 0xFF sums to 0xF0
        for (int k = 0; k < 16; k++) img[k] = 8'hFF;
        run_load(8'hF0, 1'b1, -1);
        wait_end();
        check("wrap_done", done, 1);
        check("wrap_error", error, 0);
        check_writes("wrap", 16);

        // bad checksum, then a retry start
        for (int k = 0; k < 16; k++) img[k] = 8'(k + 1);
        run_load(8'h00, 1'b0, -1);
        wait_end();
        check("bad_error", error, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        check("bad_busy", busy, 0);
        do_start();
        check("retry_error", error, 0);
        check("retry_busy", busy, 1);
        check("retry_ready", bus.in_ready, 1);
        do_reset();

        // timeout after three bytes, TIMEOUT=8
        img[0] = 8'hA0; img[1] = 8'hA1; img[2] = 8'hA2;
        wr_a.delete();
        wr_d.delete();
        do_start();
        for (int k = 0; k < 3; k++) send_byte(img[k], 1'b0);
        for (int n = 0; n < 30 && !error; n++) step();
        check("timeout_error", error, 1);
        check("timeout_delay", cyc - hs_cyc, 8);
        check("timeout_hold", cpu_hold, 1);
        check_writes("timeout", 3);
        do_reset();

        // reset mid-load, then a full load restarts at address 0
        do_start();
        for (int k = 0; k < 5; k++) send_byte(8'h55, 1'b0);
        check("midload_hold", cpu_hold, 1);
        rst_n = 1'b0;
        step();
        check("midload_reset_outputs", {bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata,
                                        cpu_hold, busy, done, error}, 0);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 16; k++) img[k] = 8'(8'h20 + 3 * k);
        run_load(8'h68, 1'b0, -1);
        wait_end();
        check("reload_done", done, 1);
        check_writes("reload", 16);

        // start pulses across RECV and WRITE cycles are ignored
        for (int k = 0; k < 16; k++) img[k] = 8'(k + 1);
        run_load(8'h88, 1'b0, 4);
        step();
        check("ignstart_cycle", cyc, 35);
        check("ignstart_done", done, 1);
        check("ignstart_error", error, 0);
        check_writes("ignstart", 16);

        check("done_error_exclusive", both_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
